parity_check: RTL

- Serial receive-side parity checker: the receiving end of the team's serial parity generator link.
- Deserialises frames of DATA_BITS data bits followed by one parity bit, sent LSB first.
- Recomputes the running parity, flags mismatches per frame and keeps a saturating error count.
- Sits between the serial line sampler and the word-level consumer.

---
 rtl/parity_pkg.sv | 6 +
 rtl/parity_check_sat_counter.sv | 14 +
 rtl/parity_check.sv | 76 +++++++
 3 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared parity-mode and receiver state encodings for the serial parity link
package parity_pkg;
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;
  typedef enum logic {DATA = 1'b0, PAR = 1'b1} state_t;
endpackage

// File: rtl/parity_check_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clr ? '0 : (inc && count != '1) ? count + CNT_W'(1) : count;
endmodule

// File: rtl/parity_check.sv
// parity_check: deserialises LSB-first data+parity frames, flags parity errors and counts them
module parity_check
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 valid,
  input  logic                 sof,
  input  logic                 clr_cnt,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     err_count
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic MODE = (ODD_PARITY != 0) ? ODD : EVEN;
  state_t state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic acc, acc_nxt, done, err, last;
  assign last = bit_cnt == BW'(DATA_BITS - 1);
  assign err = (acc ^ x) != MODE;
  // sof outranks everything, including a pending parity bit
  always_comb begin
    state_nxt = state;
    bit_cnt_nxt = bit_cnt;
    acc_nxt = acc;
    shreg_nxt = shreg;
    done = 1'b0;
    if (valid && sof) begin
      state_nxt = DATA;
      bit_cnt_nxt = BW'(1);
      acc_nxt = x;
      shreg_nxt[0] = x;
    end else if (valid && state == PAR) begin
      done = 1'b1;
      acc_nxt = 1'b0;
      state_nxt = DATA;
    end else if (valid) begin
      shreg_nxt[bit_cnt] = x;
      acc_nxt = acc ^ x;
      bit_cnt_nxt = last ? '0 : bit_cnt + BW'(1);
      state_nxt = last ? PAR : DATA;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= DATA;
      bit_cnt <= '0;
      acc <= 1'b0;
      shreg <= '0;
      data_out <= '0;
      frame_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      acc <= acc_nxt;
      shreg <= shreg_nxt;
      frame_valid <= done;
      data_out <= done ? shreg : data_out;
      parity_err <= done ? err : parity_err;
    end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (done && err),
    .clr  (clr_cnt),
    .count(err_count)
  );
endmodule
